// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing block: opcodes, datapath width and requester indices.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 3;

    localparam logic [ALU_OPW-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OPW-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OPW-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OPW-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OPW-1:0] ALU_SLT = 3'b101;

    localparam int REQ_EXEC = 0;
    localparam int REQ_ADDR = 1;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/unsigned set-less-than; unknown opcodes give 0.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; prio names the port that wins when both are valid.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        grant[0] = !rst && valid[0] && (!valid[1] || !prio_q);
        grant[1] = !rst && valid[1] && (!valid[0] ||  prio_q);
    end

    // The port just served drops to lowest priority.
    always_comb begin
        prio_d = prio_q;
        if (grant[0]) begin
            prio_d = 1'b1;
        end else if (grant[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute datapath (port 0) and the address helper (port 1).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero
);

    logic [1:0]       grant;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp0_valid_q, rsp0_valid_d;
    logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic             rsp0_zero_q, rsp0_zero_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic             rsp1_zero_q, rsp1_zero_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    // Port 0 operands also feed the ALU when idle; the result is only captured on a grant.
    always_comb begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
        if (grant[REQ_ADDR]) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        rsp0_valid_d  = grant[REQ_EXEC];
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_valid_d  = grant[REQ_ADDR];
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        if (grant[REQ_EXEC]) begin
            rsp0_result_d = alu_result;
            rsp0_zero_d   = alu_zero;
        end
        if (grant[REQ_ADDR]) begin
            rsp1_result_d = alu_result;
            rsp1_zero_d   = alu_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b1;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b1;
        end else begin
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
        end
    end

    assign req0_ready  = grant[REQ_EXEC];
    assign req1_ready  = grant[REQ_ADDR];
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_zero   = rsp1_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: grants, results, round-robin order and reset behaviour.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_op;
    logic        rsp0_valid;
    logic [31:0] rsp0_result;
    logic        rsp0_zero;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_op;
    logic        rsp1_valid;
    logic [31:0] rsp1_result;
    logic        rsp1_zero;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .rsp0_valid  (rsp0_valid),
        .rsp0_result (rsp0_result),
        .rsp0_zero   (rsp0_zero),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .rsp1_valid  (rsp1_valid),
        .rsp1_result (rsp1_result),
        .rsp1_zero   (rsp1_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle inputs/outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, "_ready0"}, {31'b0, req0_ready}, {31'b0, r0});
        chk({tag, "_ready1"}, {31'b0, req1_ready}, {31'b0, r1});
    endtask

    task automatic chk_rsp0(input string tag, input logic v, input logic [31:0] res, input logic z);
        chk({tag, "_rsp0_valid"},  {31'b0, rsp0_valid}, {31'b0, v});
        chk({tag, "_rsp0_result"}, rsp0_result, res);
        chk({tag, "_rsp0_zero"},   {31'b0, rsp0_zero}, {31'b0, z});
    endtask

    task automatic chk_rsp1(input string tag, input logic v, input logic [31:0] res, input logic z);
        chk({tag, "_rsp1_valid"},  {31'b0, rsp1_valid}, {31'b0, v});
        chk({tag, "_rsp1_result"}, rsp1_result, res);
        chk({tag, "_rsp1_zero"},   {31'b0, rsp1_zero}, {31'b0, z});
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5;    req0_b = 32'd7;    req0_op = 3'b000;
        req1_valid = 1'b1; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F; req1_op = 3'b011;

        // Reset with both requesters pending
        step();
        step();
        chk_ready("reset", 1'b0, 1'b0);
        chk_rsp0("reset", 1'b0, 32'd0, 1'b1);
        chk_rsp1("reset", 1'b0, 32'd0, 1'b1);

        // First grant after release goes to port 0
        rst = 1'b0;
        chk_ready("first", 1'b1, 1'b0);
        step();
        chk_rsp0("first", 1'b1, 32'd12, 1'b0);
        chk_rsp1("first", 1'b0, 32'd0, 1'b1);
        req0_valid = 1'b0;
        chk_ready("or1", 1'b0, 1'b1);
        step();
        chk_rsp1("or1", 1'b1, 32'h0000_00FF, 1'b0);
        chk_rsp0("hold0", 1'b0, 32'd12, 1'b0);

        // Single op on port 0 while port 1 idle: sub 10-10
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd10; req0_op = 3'b001;
        chk_ready("single", 1'b1, 1'b0);
        step();
        chk_rsp0("single", 1'b1, 32'd0, 1'b1);
        chk_rsp1("single", 1'b0, 32'h0000_00FF, 1'b0);

        // Contention: prio is now 1, so grants go 1,0,1,0
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                chk_ready("cont", 1'b0, 1'b1);
                step();
                chk_rsp1("cont", 1'b1, 32'h0000_00FF, 1'b0);
                chk({"cont_rsp0_idle"}, {31'b0, rsp0_valid}, 32'd0);
            end else begin
                chk_ready("cont", 1'b1, 1'b0);
                step();
                chk_rsp0("cont", 1'b1, 32'd0, 1'b1);
                chk({"cont_rsp1_idle"}, {31'b0, rsp1_valid}, 32'd0);
            end
        end

        // Wrap-around add and unsigned slt on port 1 alone
        req0_valid = 1'b0;
        req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = 3'b000;
        chk_ready("wrap", 1'b0, 1'b1);
        step();
        chk_rsp1("wrap", 1'b1, 32'd0, 1'b1);
        req1_a = 32'd3; req1_b = 32'hFFFF_FFFF; req1_op = 3'b101;
        chk_ready("slt", 1'b0, 1'b1);
        step();
        chk_rsp1("slt", 1'b1, 32'd1, 1'b0);
        req1_a = 32'hFFFF_FFFF; req1_b = 32'd3; req1_op = 3'b101;
        chk_ready("sltf", 1'b0, 1'b1);
        step();
        chk_rsp1("sltf", 1'b1, 32'd0, 1'b1);

        // Sub underflow and AND on port 0
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd1; req0_op = 3'b001;
        step();
        chk_rsp0("subwrap", 1'b1, 32'hFFFF_FFFF, 1'b0);
        req0_a = 32'h0000_F0F0; req0_b = 32'h0000_FF00; req0_op = 3'b010;
        step();
        chk_rsp0("and", 1'b1, 32'h0000_F000, 1'b0);

        // Illegal opcode: completes with result 0, zero 1
        req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b110;
        chk_ready("illegal", 1'b1, 1'b0);
        step();
        chk_rsp0("illegal", 1'b1, 32'd0, 1'b1);

        // prio moved to port 1 after the illegal transfer
        req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd3; req1_op = 3'b010;
        chk_ready("prio1", 1'b0, 1'b1);

        // Reset on the accept edge of req1: no pulse, prio back to 0
        rst = 1'b1;
        chk_ready("rstmid", 1'b0, 1'b0);
        step();
        chk_rsp0("rstmid", 1'b0, 32'd0, 1'b1);
        chk_rsp1("rstmid", 1'b0, 32'd0, 1'b1);
        rst = 1'b0;
        chk_ready("after", 1'b1, 1'b0);
        step();
        chk_rsp0("after", 1'b1, 32'd2, 1'b0);
        chk_rsp1("after", 1'b0, 32'd0, 1'b1);
        req0_valid = 1'b0;
        chk_ready("after1", 1'b0, 1'b1);
        step();
        chk_rsp1("after1", 1'b1, 32'd2, 1'b0);
        chk_rsp0("after1", 1'b0, 32'd2, 1'b0);
        req1_valid = 1'b0;
        chk_ready("idle", 1'b0, 1'b0);
        step();
        chk({"idle_rsp1_valid"}, {31'b0, rsp1_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
